// File: rtl/mem_stage.sv
// Memory stage of the pipeline: turns a load/store into a single request on a
// handshaked data-memory port and stalls the upstream pipe until it completes.
module mem_stage #(
    parameter logic [31:0] BASE_ADDR = 32'd1024,
    parameter logic [7:0]  TIMEOUT   = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        WB_EN_IN,
    input  logic        MEM_R_EN_IN,
    input  logic        MEM_W_EN_IN,
    input  logic [31:0] ALUResIn,
    input  logic [31:0] STValIn,
    input  logic [4:0]  destIn,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        WB_EN,
    output logic        MEM_R_EN,
    output logic [31:0] ALURes,
    output logic [31:0] memData,
    output logic [4:0]  dest,
    output logic        freeze,
    output logic        mem_err
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state_reg, state_next;
    logic [7:0]  cnt_reg, cnt_next;
    logic        mem_err_reg, mem_err_next;
    logic [31:0] mem_data_reg, mem_data_next;
    logic        mem_we_reg, mem_we_next;
    logic [31:0] mem_addr_reg, mem_addr_next;
    logic [31:0] mem_wdata_reg, mem_wdata_next;

    logic access;
    logic misaligned;
    logic start;
    logic timeout_hit;

    assign access     = MEM_R_EN_IN | MEM_W_EN_IN;
    assign misaligned = access & (ALUResIn[1:0] != 2'b00);
    assign start      = access & ~misaligned;
    // Widened compare so TIMEOUT = 255 cannot overflow the counter increment.
    assign timeout_hit = ({1'b0, cnt_reg} + 9'd1) >= {1'b0, TIMEOUT};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 8'd0;
            mem_err_reg   <= 1'b0;
            mem_data_reg  <= 32'd0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= 32'd0;
            mem_wdata_reg <= 32'd0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            mem_err_reg   <= mem_err_next;
            mem_data_reg  <= mem_data_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        mem_err_next   = mem_err_reg | misaligned;
        mem_data_next  = mem_data_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next     = BUSY;
                    cnt_next       = 8'd0;
                    mem_we_next    = MEM_W_EN_IN;
                    mem_addr_next  = ALUResIn - BASE_ADDR;
                    mem_wdata_next = STValIn;
                end
            end
            BUSY: begin
                if (mem_ack) begin
                    if (!mem_we_reg) begin
                        mem_data_next = mem_rdata;
                    end
                    state_next = DONE;
                end else if (timeout_hit) begin
                    cnt_next      = TIMEOUT;
                    mem_data_next = 32'd0;
                    mem_err_next  = 1'b1;
                    state_next    = DONE;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
            // The instruction is still presented here; returning to IDLE
            // without looking at it prevents a duplicate request.
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign freeze    = ((state_reg == IDLE) & start) | (state_reg == BUSY);
    assign mem_req   = (state_reg == BUSY);
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_err   = mem_err_reg;
    assign memData   = mem_data_reg;

    assign WB_EN    = WB_EN_IN & ~freeze & ~misaligned;
    assign MEM_R_EN = MEM_R_EN_IN & ~freeze & ~misaligned;
    assign ALURes   = ALUResIn;
    assign dest     = destIn;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: each access pushes its expected outcome to a
// scoreboard that is popped and checked when the stage finishes the access.
module tb_mem_stage;

    localparam logic [31:0] BASE = 32'd1024;
    localparam logic [7:0]  TMO  = 8'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN;
    logic [31:0] ALUResIn, STValIn;
    logic [4:0]  destIn;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        WB_EN, MEM_R_EN;
    logic [31:0] ALURes, memData;
    logic [4:0]  dest;
    logic        freeze, mem_err;

    mem_stage #(.BASE_ADDR(BASE), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .WB_EN_IN(WB_EN_IN), .MEM_R_EN_IN(MEM_R_EN_IN), .MEM_W_EN_IN(MEM_W_EN_IN),
        .ALUResIn(ALUResIn), .STValIn(STValIn), .destIn(destIn),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .ALURes(ALURes), .memData(memData),
        .dest(dest), .freeze(freeze), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          freeze_cyc;
        int          req_cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    logic [31:0] model_data;
    logic        model_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        WB_EN_IN = 1'b0; MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0;
        ALUResIn = 32'd0; STValIn = 32'd0; destIn = 5'd0;
        mem_ack = 1'b0; mem_rdata = 32'd0;
    endtask

    // One non-memory instruction; optionally with a stray ack on the port.
    task automatic nop_cycle(input string tag, input logic [31:0] res, input logic stray_ack);
        WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b0; MEM_W_EN_IN = 1'b0;
        ALUResIn = res; destIn = 5'd9;
        mem_ack = stray_ack; mem_rdata = 32'hFEED_0001;
        @(negedge clk);
        chk({tag, "_freeze"}, {31'd0, freeze}, 32'd0);
        chk({tag, "_wb_en"}, {31'd0, WB_EN}, 32'd1);
        chk({tag, "_alures"}, ALURes, res);
        chk({tag, "_dest"}, {27'd0, dest}, 32'd9);
        chk({tag, "_req"}, {31'd0, mem_req}, 32'd0);
        @(posedge clk); #1;
        idle_inputs();
        chk({tag, "_memdata_hold"}, memData, model_data);
        $display("txn %s: nop ALURes=%h memData=%h", tag, ALURes, memData);
    endtask

    // waits = BUSY cycles without ack before the ack cycle; negative = never ack.
    task automatic do_access(input string tag, input logic ld, input logic [31:0] addr,
                             input logic [31:0] sval, input int waits, input logic [31:0] rdata);
        exp_t e;
        int   fcnt, rcnt;
        logic aligned, done;
        aligned = (addr[1:0] == 2'b00);
        e.addr = addr - BASE; e.we = ~ld; e.wdata = sval;
        if (!aligned) begin
            e.freeze_cyc = 0; e.req_cyc = 0; e.err = 1'b1; e.data = model_data;
        end else if (waits < 0) begin
            e.req_cyc = int'(TMO); e.freeze_cyc = int'(TMO) + 1; e.data = 32'd0; e.err = 1'b1;
        end else begin
            e.req_cyc = waits + 1; e.freeze_cyc = waits + 2;
            e.data = ld ? rdata : model_data; e.err = model_err;
        end
        model_data = e.data;
        model_err  = e.err;
        sb.push_back(e);

        WB_EN_IN = ld; MEM_R_EN_IN = ld; MEM_W_EN_IN = ~ld;
        ALUResIn = addr; STValIn = sval; destIn = 5'd17;
        fcnt = 0; rcnt = 0; done = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            mem_ack   = mem_req && (waits >= 0) && (rcnt == waits);
            mem_rdata = mem_ack ? rdata : $urandom;
            @(negedge clk);
            if (mem_req) begin
                rcnt++;
                chk({tag, "_addr"}, mem_addr, e.addr);
                chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, e.we});
                chk({tag, "_wdata"}, mem_wdata, e.wdata);
            end
            if (freeze) begin
                fcnt++;
                chk({tag, "_wb_en_stall"}, {31'd0, WB_EN}, 32'd0);
                chk({tag, "_mem_r_en_stall"}, {31'd0, MEM_R_EN}, 32'd0);
            end else begin
                chk({tag, "_req_after"}, {31'd0, mem_req}, 32'd0);
                chk({tag, "_wb_en_done"}, {31'd0, WB_EN}, {31'd0, ld & aligned});
                chk({tag, "_mem_r_en_done"}, {31'd0, MEM_R_EN}, {31'd0, ld & aligned});
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        if (!done) chk({tag, "_bound"}, {31'd0, done}, 32'd1);
        e = sb.pop_front();
        chk({tag, "_freeze_cycles"}, 32'(fcnt), 32'(e.freeze_cyc));
        chk({tag, "_req_cycles"}, 32'(rcnt), 32'(e.req_cyc));
        chk({tag, "_memdata"}, memData, e.data);
        chk({tag, "_mem_err"}, {31'd0, mem_err}, {31'd0, e.err});
        $display("txn %s: %s addr=%h freeze=%0d req=%0d memData=%h err=%b",
                 tag, ld ? "load" : "store", addr, fcnt, rcnt, memData, mem_err);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_data = 32'd0;
        model_err  = 1'b0;
    endtask

    initial begin
        idle_inputs();
        do_reset();
        @(negedge clk);
        chk("rst_memdata", memData, 32'd0);
        chk("rst_err", {31'd0, mem_err}, 32'd0);
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_we", {31'd0, mem_we}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_freeze", {31'd0, freeze}, 32'd0);
        $display("txn reset: memData=%h err=%b", memData, mem_err);
        @(posedge clk); #1;

        do_access("load0", 1'b1, 32'd1028, 32'd0, 0, 32'h1234_5678);
        do_access("store0", 1'b0, 32'd1032, 32'hCAFE_F00D, 2, 32'd0);
        do_access("b2b_a", 1'b1, 32'd1040, 32'd0, 0, 32'hA5A5_0001);
        do_access("b2b_b", 1'b1, 32'd1044, 32'd0, 0, 32'h5A5A_0002);
        nop_cycle("nop0", 32'h0000_0777, 1'b0);
        nop_cycle("stray_ack", 32'h0000_0888, 1'b1);
        do_access("misalign", 1'b1, 32'd1026, 32'd0, 0, 32'h1111_1111);
        do_access("err_sticky", 1'b1, 32'd1048, 32'd0, 1, 32'h2222_2222);

        do_reset();
        do_access("timeout", 1'b1, 32'd1052, 32'd0, -1, 32'd0);

        do_reset();
        do_access("pre_rst", 1'b1, 32'd1056, 32'd0, 0, 32'h55AA_55AA);
        // Reset lands in the second BUSY cycle; the ack arrives one cycle later.
        WB_EN_IN = 1'b1; MEM_R_EN_IN = 1'b1; ALUResIn = 32'd1060; destIn = 5'd3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        chk("rst_busy_req_before", {31'd0, mem_req}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("rst_busy_req_after", {31'd0, mem_req}, 32'd0);
        chk("rst_busy_freeze", {31'd0, freeze}, 32'd0);
        @(posedge clk); #1;
        mem_ack = 1'b0;
        @(negedge clk);
        chk("rst_busy_memdata", memData, 32'd0);
        chk("rst_busy_err", {31'd0, mem_err}, 32'd0);
        chk("rst_busy_req_late", {31'd0, mem_req}, 32'd0);
        $display("txn rst_busy: req=%b memData=%h err=%b", mem_req, memData, mem_err);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter BASE_ADDR, default 32'd1024, byte address of data-memory word 0.
REQ-002 Parameter TIMEOUT, default 8'd255, maximum cycles spent waiting for mem_ack before abort.
REQ-003 clk  input  1  clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 WB_EN_IN, MEM_R_EN_IN, MEM_W_EN_IN  input  1 each  control bits from the EXE/MEM pipe register.
REQ-006 ALUResIn  input  32  byte address (loads/stores) or ALU result (others); STValIn  input  32  store data; destIn  input  5  destination register.
REQ-007 mem_req  output  1  memory request; mem_we  output  1  1 = write, 0 = read; mem_addr  output  32  byte offset; mem_wdata  output  32  write data.
REQ-008 mem_ack  input  1  single-cycle completion strobe; mem_rdata  input  32  read data, valid with mem_ack.
REQ-009 WB_EN, MEM_R_EN  output  1 each  to MEM/WB register; ALURes  output  32  pass-through of ALUResIn; memData  output  32  registered load data; dest  output  5  pass-through of destIn.
REQ-010 freeze  output  1  stall to PC, IF/ID, ID/EXE and EXE/MEM registers, which hold while high.
REQ-011 mem_err  output  1  sticky error: misaligned access or timeout.

Function
REQ-012 FSM states: IDLE, BUSY, DONE; reset state IDLE.
REQ-013 access = MEM_R_EN_IN | MEM_W_EN_IN; misaligned = access & (ALUResIn[1:0] != 0).
REQ-014 IDLE: access & ~misaligned -> BUSY, latching mem_we = MEM_W_EN_IN, mem_addr = ALUResIn - BASE_ADDR (32-bit modulo), mem_wdata = STValIn; otherwise stay IDLE.
REQ-015 freeze = (IDLE & access & ~misaligned) | BUSY; combinational; 0 in DONE.
REQ-016 mem_req = 1 exactly while in BUSY; mem_we/mem_addr/mem_wdata stable for the whole of BUSY.
REQ-017 BUSY with mem_ack: memData <= mem_rdata if read (unchanged if write), -> DONE.
REQ-018 BUSY without mem_ack: wait counter increments; counter reaching TIMEOUT -> DONE, memData <= 0, mem_err <= 1.
REQ-019 DONE -> IDLE unconditionally; no new access starts from DONE, even though the same instruction is still presented.
REQ-020 Minimum load/store latency: 1 IDLE cycle + ack cycle(s) in BUSY + 1 DONE cycle; zero-wait memory (ack in first BUSY cycle) gives 2 freeze cycles.
REQ-021 WB_EN = WB_EN_IN & ~freeze & ~misaligned; MEM_R_EN = MEM_R_EN_IN & ~freeze & ~misaligned; bubbles while stalled.
REQ-022 Misaligned access: no request, no stall, WB_EN = 0, mem_err <= 1 at next edge.
REQ-023 Non-memory instruction: zero latency; WB_EN = WB_EN_IN, no freeze, memData holds.
REQ-024 mem_ack outside BUSY is ignored.
REQ-025 Wait counter is 8 bits, cleared on entry to BUSY, and never wraps (saturates at TIMEOUT).

Reset
REQ-026 rst high at a clock edge: state IDLE, counter 0, mem_err 0, memData 0, mem_we 0, mem_addr 0, mem_wdata 0; takes priority over all other transitions.
REQ-027 rst during BUSY: mem_req drops in the next cycle; any later mem_ack is ignored; no data captured.

Verification
REQ-028 Load, ALUResIn=1028, ack in first BUSY cycle, mem_rdata=0x12345678 -> mem_addr=4, mem_we=0, freeze high 2 cycles, memData=0x12345678, WB_EN=1 in DONE only.
REQ-029 Store, ALUResIn=1032, STValIn=0xCAFEF00D, ack after 3 BUSY cycles -> mem_req high 3 cycles, mem_we=1, mem_wdata=0xCAFEF00D, freeze high 4 cycles.
REQ-030 Load, ALUResIn=1026 -> mem_req never asserted, freeze 0, WB_EN=0, mem_err=1 next cycle and stays 1 until rst.
REQ-031 Load with no ack, TIMEOUT=4 -> DONE after 4 BUSY cycles, memData=0, mem_err=1.
REQ-032 rst asserted in second BUSY cycle, then ack one cycle later -> mem_req=0, state IDLE, memData=0, mem_err=0.
REQ-033 Back-to-back loads, each acked immediately -> IDLE-BUSY-DONE per load (3 cycles each), no duplicate request from DONE, 2 freeze cycles per load.
